// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
//   Definitions shared by the sequence-detector lock and the code sender:
//   the FSM state encodings of the sender, the factory unlock code and its
//   length, and a helper that sizes counters.
//   No ports (package).
// -----------------------------------------------------------------------------
package lock_pkg;

    // Number of symbols in the factory code.
    localparam int LOCK_CODE_LEN = 6;

    // Factory unlock code, sent MSB first: symbols 0,1,1,0,0,1.
    localparam logic [LOCK_CODE_LEN-1:0] DEFAULT_CODE = 6'b011001;

    // Sender FSM state encodings (3 bits, kept as plain constants so older
    // blocks that compare against raw codes stay compatible).
    typedef logic [2:0] sender_state_t;

    localparam sender_state_t ST_IDLE = 3'd0;
    localparam sender_state_t ST_LRST = 3'd1;
    localparam sender_state_t ST_SEND = 3'd2;
    localparam sender_state_t ST_GAP  = 3'd3;
    localparam sender_state_t ST_WAIT = 3'd4;
    localparam sender_state_t ST_DONE = 3'd5;
    localparam sender_state_t ST_FAIL = 3'd6;

    // Width of a counter sized as $clog2(n), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : lock_pkg

// File: rtl/lock_delay_timer.sv
// -----------------------------------------------------------------------------
// lock_delay_timer
//   Loadable down-counter used to time a fixed number of cycles. A load
//   copies value into the counter; otherwise it counts down and parks at 0.
//   expired is high while the counter reads 0, so loading value = N-1 marks
//   the N-th cycle after the load as the last one.
// Ports
//   clk      in   1      clock, posedge
//   reset    in   1      synchronous, active-high; clears the counter
//   load     in   1      reload the counter from value
//   value    in   WIDTH  reload value
//   expired  out  1      counter is at 0
// -----------------------------------------------------------------------------
module lock_delay_timer
    import lock_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule : lock_delay_timer

// File: rtl/lock_code_sender.sv
// -----------------------------------------------------------------------------
// lock_code_sender
//   Transmit side of the lock keypad interface. On start it latches a code,
//   resets the lock, replays the code MSB first as one-cycle zero/one pulses
//   separated by GAP idle cycles, then waits up to UNLOCK_WAIT cycles for the
//   lock's unlock line. A timeout retries from the lock reset until
//   MAX_TRIES attempts have been made, after which fail is pulsed.
// Ports
//   clk         in   1         clock, posedge
//   reset       in   1         synchronous, active-high
//   start       in   1         begin transmission, sampled only in IDLE
//   code        in   CODE_LEN  code to send, latched when start is accepted
//   unlock      in   1         unlock feedback from the lock, used in WAIT only
//   zero        out  1         one-cycle pulse, symbol 0
//   one         out  1         one-cycle pulse, symbol 1
//   lock_reset  out  1         one-cycle pulse, returns the lock to its start
//   busy        out  1         attempt sequence in progress
//   done        out  1         one-cycle pulse, lock opened
//   fail        out  1         one-cycle pulse, all attempts used up
// -----------------------------------------------------------------------------
module lock_code_sender
    import lock_pkg::*;
#(
    parameter int CODE_LEN    = LOCK_CODE_LEN,
    parameter int GAP         = 2,
    parameter int UNLOCK_WAIT = 4,
    parameter int MAX_TRIES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    input  logic                unlock,
    output logic                zero,
    output logic                one,
    output logic                lock_reset,
    output logic                busy,
    output logic                done,
    output logic                fail
);

    localparam int IDX_W  = cnt_width(CODE_LEN);
    localparam int GAP_W  = cnt_width(GAP + 1);
    localparam int WAIT_W = cnt_width(UNLOCK_WAIT + 1);
    localparam int TRY_W  = cnt_width(MAX_TRIES + 1);

    // Timers are loaded with N-1 so that they read 0 in the N-th cycle.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(UNLOCK_WAIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);

    sender_state_t       state;
    sender_state_t       state_nxt;
    logic [CODE_LEN-1:0] code_q;      // code latched on start, reused on retries
    logic [CODE_LEN-1:0] shreg;       // per-attempt copy, MSB is the next symbol
    logic [CODE_LEN-1:0] shreg_nxt;
    logic [IDX_W-1:0]    idx_q;       // index of the symbol being sent
    logic [TRY_W-1:0]    try_cnt;     // attempt number, 1-based
    logic                gap_load;
    logic                gap_expired;
    logic                wait_load;
    logic                wait_expired;

    // -------------------------------------------------------------------------
    // Cycle timers
    // -------------------------------------------------------------------------
    lock_delay_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (gap_load),
        .value   (GAP_LOAD),
        .expired (gap_expired)
    );

    lock_delay_timer #(
        .WIDTH (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (wait_load),
        .value   (WAIT_LOAD),
        .expired (wait_expired)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LRST;
                end
            end
            ST_LRST: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (idx_q == '0) begin
                    state_nxt = ST_WAIT;
                end else if (GAP == 0) begin
                    state_nxt = ST_SEND;
                end else begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_expired) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_WAIT: begin
                // A sampled unlock wins over a timeout in the same cycle.
                if (unlock) begin
                    state_nxt = ST_DONE;
                end else if (wait_expired) begin
                    state_nxt = (try_cnt < TRY_MAX) ? ST_LRST : ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The shift register is refilled from the latched code in LRST, so every
    // retry replays the full code, and it advances once per SEND cycle.
    always_comb begin
        case (state)
            ST_LRST: shreg_nxt = code_q;
            ST_SEND: shreg_nxt = shreg << 1;
            default: shreg_nxt = shreg;
        endcase
    end

    assign gap_load  = (state == ST_SEND) && (state_nxt == ST_GAP);
    assign wait_load = (state == ST_SEND) && (state_nxt == ST_WAIT);

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    // Outputs are decoded from the next state so that each pulse appears in
    // the same cycle the FSM occupies the matching state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            code_q     <= '0;
            shreg      <= '0;
            idx_q      <= '0;
            try_cnt    <= '0;
            zero       <= 1'b0;
            one        <= 1'b0;
            lock_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;

            if ((state == ST_IDLE) && start) begin
                code_q  <= code;
                try_cnt <= TRY_W'(1);
            end else if ((state == ST_WAIT) && (state_nxt == ST_LRST)) begin
                try_cnt <= try_cnt + TRY_W'(1);
            end

            if (state == ST_LRST) begin
                idx_q <= IDX_LAST;
            end else if ((state == ST_SEND) && (idx_q != '0)) begin
                idx_q <= idx_q - IDX_W'(1);
            end

            zero       <= (state_nxt == ST_SEND) && !shreg_nxt[CODE_LEN-1];
            one        <= (state_nxt == ST_SEND) &&  shreg_nxt[CODE_LEN-1];
            lock_reset <= (state_nxt == ST_LRST);
            busy       <= (state_nxt == ST_LRST) || (state_nxt == ST_SEND) ||
                          (state_nxt == ST_GAP)  || (state_nxt == ST_WAIT);
            done       <= (state_nxt == ST_DONE);
            fail       <= (state_nxt == ST_FAIL);
        end
    end

endmodule : lock_code_sender

// File: tb/tb_lock_code_sender.sv
// -----------------------------------------------------------------------------
// tb_lock_code_sender
//   Two senders (GAP=2 and GAP=0) each drive a behavioural sequence-detector
//   lock. Each run's pulse schedule, lock resets, done/fail timing and busy
//   duration are compared with a timing model derived from the attempt
//   length. The lock output can be held closed for the first attempts.
// -----------------------------------------------------------------------------
module tb_lock_code_sender;
    import lock_pkg::*;

    localparam int L  = LOCK_CODE_LEN;
    localparam int W  = 4;
    localparam int N  = 3;
    localparam int G0 = 2;
    localparam int G1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [1:0]    start_v;
    logic [L-1:0]  code_v [2];
    wire  [1:0]    unlock_v;
    wire  [1:0]    zero_v, one_v, lrst_v, busy_v, done_v, fail_v;

    lock_code_sender #(
        .CODE_LEN (L), .GAP (G0), .UNLOCK_WAIT (W), .MAX_TRIES (N)
    ) dut0 (
        .clk (clk), .reset (reset), .start (start_v[0]), .code (code_v[0]),
        .unlock (unlock_v[0]), .zero (zero_v[0]), .one (one_v[0]),
        .lock_reset (lrst_v[0]), .busy (busy_v[0]), .done (done_v[0]),
        .fail (fail_v[0])
    );

    lock_code_sender #(
        .CODE_LEN (L), .GAP (G1), .UNLOCK_WAIT (W), .MAX_TRIES (N)
    ) dut1 (
        .clk (clk), .reset (reset), .start (start_v[1]), .code (code_v[1]),
        .unlock (unlock_v[1]), .zero (zero_v[1]), .one (one_v[1]),
        .lock_reset (lrst_v[1]), .busy (busy_v[1]), .done (done_v[1]),
        .fail (fail_v[1])
    );

    // ---------------- cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural locks ----------------
    // Opens when the last L symbols received equal DEFAULT_CODE; stays open
    // until the next symbol or reset. Reset is lock_reset | reset.
    logic [L-1:0] hist [2];
    int           hcnt [2];
    logic [1:0]   lk_open;
    int           lrst_cnt [2] = '{0, 0};
    int           lrst_base [2] = '{0, 0};
    int           stuck [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || lrst_v[i]) begin
                hist[i]    <= '0;
                hcnt[i]    <= 0;
                lk_open[i] <= 1'b0;
            end else if (zero_v[i] || one_v[i]) begin
                hist[i]    <= {hist[i][L-2:0], one_v[i]};
                hcnt[i]    <= (hcnt[i] < L) ? hcnt[i] + 1 : L;
                lk_open[i] <= (hcnt[i] + 1 >= L) &&
                              ({hist[i][L-2:0], one_v[i]} == DEFAULT_CODE);
            end
            if (lrst_v[i]) lrst_cnt[i] <= lrst_cnt[i] + 1;
        end
    end

    // Lock held closed during the first stuck[i] attempts of a run.
    assign unlock_v[0] = lk_open[0] && ((lrst_cnt[0] - lrst_base[0]) > stuck[0]);
    assign unlock_v[1] = lk_open[1] && ((lrst_cnt[1] - lrst_base[1]) > stuck[1]);

    // ---------------- output monitor ----------------
    int lrst_q [2][$];
    int pc_q   [2][$];
    bit ps_q   [2][$];
    int done_q [2][$];
    int fail_q [2][$];
    int busy_cnt [2] = '{0, 0};
    int ovl_cnt  [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (lrst_v[i]) lrst_q[i].push_back(cyc);
            if (zero_v[i] || one_v[i]) begin
                pc_q[i].push_back(cyc);
                ps_q[i].push_back(one_v[i]);
            end
            if (done_v[i]) done_q[i].push_back(cyc);
            if (fail_v[i]) fail_q[i].push_back(cyc);
            if (busy_v[i]) busy_cnt[i]++;
            if ($countones({zero_v[i], one_v[i], lrst_v[i], done_v[i], fail_v[i]}) > 1)
                ovl_cnt[i]++;
        end
    end

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, after the monitor.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One complete run on sender i with code c; the lock stays closed for
    // the first stk attempts. disturb toggles start/code while busy.
    task automatic do_run(input string tag, input int i, input logic [L-1:0] c,
                          input int stk, input bit disturb);
        int g, a, open_at, tries, t, end_cyc, limit, att, k;
        int nb_l, nb_p, nb_d, nb_f, nb_b, nb_o;
        g       = (i == 0) ? G0 : G1;
        a       = 1 + (L - 1) * (g + 1) + 1 + W;   // cycles per attempt
        open_at = ((c == DEFAULT_CODE) && (stk < N)) ? stk + 1 : 0;
        tries   = (open_at != 0) ? open_at : N;
        stuck[i]     = stk;
        lrst_base[i] = lrst_cnt[i];
        nb_l = lrst_q[i].size(); nb_p = pc_q[i].size();
        nb_d = done_q[i].size(); nb_f = fail_q[i].size();
        nb_b = busy_cnt[i];      nb_o = ovl_cnt[i];

        code_v[i]  = c;
        start_v[i] = 1'b1;
        t = cyc;
        tick();
        start_v[i] = 1'b0;
        if (disturb) begin
            repeat (8) begin
                start_v[i] = 1'($urandom % 2);
                code_v[i]  = L'($urandom);
                tick();
            end
            start_v[i] = 1'b0;
        end

        limit = N * a + 20;
        while ((done_q[i].size() == nb_d) && (fail_q[i].size() == nb_f) && (cyc - t < limit))
            tick();
        check({tag, "_finished"},
              32'((done_q[i].size() != nb_d) || (fail_q[i].size() != nb_f)), 1);
        repeat (3) tick();

        check({tag, "_lrst_count"}, lrst_q[i].size() - nb_l, tries);
        for (int j = 0; j < tries && nb_l + j < lrst_q[i].size(); j++)
            check($sformatf("%s_lrst%0d_cyc", tag, j), lrst_q[i][nb_l + j], t + 1 + j * a);

        check({tag, "_pulse_count"}, pc_q[i].size() - nb_p, tries * L);
        for (int j = 0; j < tries * L && nb_p + j < pc_q[i].size(); j++) begin
            att = j / L;
            k   = j % L;
            check($sformatf("%s_p%0d_cyc", tag, j), pc_q[i][nb_p + j],
                  t + 1 + att * a + 1 + k * (g + 1));
            check($sformatf("%s_p%0d_sym", tag, j), 32'(ps_q[i][nb_p + j]), 32'(c[L-1-k]));
        end

        if (open_at != 0) begin
            end_cyc = t + 1 + (open_at - 1) * a + 1 + (L - 1) * (g + 1) + 2;
            check({tag, "_done_count"}, done_q[i].size() - nb_d, 1);
            check({tag, "_fail_count"}, fail_q[i].size() - nb_f, 0);
            if (done_q[i].size() > nb_d)
                check({tag, "_done_cyc"}, done_q[i][nb_d], end_cyc);
        end else begin
            end_cyc = t + 1 + N * a;
            check({tag, "_fail_count"}, fail_q[i].size() - nb_f, 1);
            check({tag, "_done_count"}, done_q[i].size() - nb_d, 0);
            if (fail_q[i].size() > nb_f)
                check({tag, "_fail_cyc"}, fail_q[i][nb_f], end_cyc);
        end
        check({tag, "_busy_cycles"}, busy_cnt[i] - nb_b, end_cyc - (t + 1));
        check({tag, "_overlap"}, ovl_cnt[i] - nb_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t, nd, nf, ri;
        logic [L-1:0] rc;
        reset     = 1'b1;
        start_v   = '0;
        code_v[0] = '0;
        code_v[1] = '0;
        repeat (3) tick();
        check("reset_out0", 32'({zero_v[0], one_v[0], lrst_v[0], busy_v[0], done_v[0], fail_v[0]}), 0);
        check("reset_out1", 32'({zero_v[1], one_v[1], lrst_v[1], busy_v[1], done_v[1], fail_v[1]}), 0);
        reset = 1'b0;
        tick();

        do_run("happy", 0, DEFAULT_CODE, 0, 1'b0);
        do_run("wrong", 0, 6'b111111, 0, 1'b0);
        do_run("b2b", 1, DEFAULT_CODE, 0, 1'b0);
        do_run("stuck1", 0, DEFAULT_CODE, 1, 1'b0);
        check("stuck1_try_cnt", 32'(dut0.try_cnt), 2);

        // Reset during the third pulse of a happy-path run.
        stuck[0]     = 0;
        lrst_base[0] = lrst_cnt[0];
        code_v[0]    = DEFAULT_CODE;
        start_v[0]   = 1'b1;
        t = cyc;
        tick();
        start_v[0] = 1'b0;
        while (cyc < t + 8) tick();
        check("midrst_pulse3", 32'(one_v[0]), 1);
        reset = 1'b1;
        tick();
        check("midrst_outputs", 32'({zero_v[0], one_v[0], lrst_v[0], busy_v[0], done_v[0], fail_v[0]}), 0);
        reset = 1'b0;
        nd = done_q[0].size();
        nf = fail_q[0].size();
        repeat (30) tick();
        check("midrst_no_end_pulse", (done_q[0].size() - nd) + (fail_q[0].size() - nf), 0);
        do_run("after_rst", 0, DEFAULT_CODE, 0, 1'b0);

        do_run("disturb", 0, DEFAULT_CODE, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            ri = $urandom % 2;
            rc = ($urandom % 2 == 0) ? DEFAULT_CODE : L'($urandom);
            do_run($sformatf("rnd%0d", r), ri, rc, $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed %0d checks, expected completion", n_total);
        $fatal(1);
    end

endmodule : tb_lock_code_sender
